// File: rtl/sr_latch_drv_pkg.sv
// ---------------------------------------------------------------------------
// sr_latch_drv_pkg
//
// Shared types and constants for the SR latch command driver.
//   drv_state_t : FSM state encoding (IDLE, PULSE, SETTLE, CHECK)
//   CMD_SET     : command value that drives the latch to Q=1
//   CMD_RESET   : command value that drives the latch to Q=0
// ---------------------------------------------------------------------------
package sr_latch_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } drv_state_t;

    localparam logic CMD_SET   = 1'b1;
    localparam logic CMD_RESET = 1'b0;

endpackage

// File: rtl/sr_drv_timer.sv
// ---------------------------------------------------------------------------
// sr_drv_timer
//
// Loadable down-counter with a zero flag. One instance is shared by the
// PULSE and SETTLE phases of the driver; the FSM reloads it on each phase
// change. The counter parks at zero until the next load.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (has priority over counting)
//   load_val in   value to load
//   zero     out  count == 0
// ---------------------------------------------------------------------------
module sr_drv_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// ---------------------------------------------------------------------------
// sr_latch_driver
//
// Clocked command-side controller for a cross-coupled NOR SR latch. A
// command (set or reset) is accepted over valid/ready, a fixed-width S or R
// pulse is driven, the latch is left to settle, and then the Q/Qn readback
// is checked before a one-cycle done pulse is issued.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, requesters hold
// cmd_valid (and cmd_set stable) until the transfer, and cmd_valid seen
// while busy has no effect.
//
// Compile-time option:
//   SR_LATCH_DRIVER_VERIFY_EN  when defined, CHECK compares q_fb/qn_fb with
//                              the target and retries up to MAX_RETRY times.
//                              When undefined, CHECK always passes and the
//                              readback inputs are ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command request
//   cmd_set    in   1 = set (Q=1), 0 = reset (Q=0); sampled on accept
//   cmd_ready  out  high only in IDLE
//   S, R       out  registered latch inputs, never high together
//   q_fb       in   latch Q readback
//   qn_fb      in   latch Qn readback
//   done       out  one-cycle completion pulse
//   ok         out  result qualifying done; held until the next done
//   busy       out  high in any state other than IDLE
//   state_dbg  out  current FSM state (drv_state_t encoding)
// ---------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_set,
    output logic       cmd_ready,
    output logic       S,
    output logic       R,
    input  logic       q_fb,
    input  logic       qn_fb,
    output logic       done,
    output logic       ok,
    output logic       busy,
    output logic [1:0] state_dbg
);

    import sr_latch_drv_pkg::*;

    localparam int MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);

    drv_state_t    state, state_next;
    logic          target, target_next;
    logic          done_next, ok_next;
    logic          s_next, r_next;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          chk_pass;

`ifdef SR_LATCH_DRIVER_VERIFY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    logic [RW-1:0] retry_cnt, retry_next;

    // Q==Qn (both 0 or both 1) never matches, so an invalid readback fails.
    assign chk_pass = (q_fb == target) && (qn_fb == !target);
`else
    localparam int unused_max_retry = MAX_RETRY;
    logic unused_fb;

    assign unused_fb = q_fb ^ qn_fb;
    assign chk_pass  = 1'b1;
`endif

    sr_drv_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            target    <= CMD_RESET;
            S         <= 1'b0;
            R         <= 1'b0;
            done      <= 1'b0;
            ok        <= 1'b0;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
            retry_cnt <= '0;
`endif
        end else begin
            state     <= state_next;
            target    <= target_next;
            S         <= s_next;
            R         <= r_next;
            done      <= done_next;
            ok        <= ok_next;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
            retry_cnt <= retry_next;
`endif
        end
    end

    // ------------------------------------------------- next state / outputs
    always_comb begin
        state_next  = state;
        target_next = target;
        done_next   = 1'b0;
        ok_next     = ok;
        tmr_load    = 1'b0;
        tmr_val     = PULSE_LOAD;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
        retry_next  = retry_cnt;
`endif

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    target_next = cmd_set;
                    tmr_load    = 1'b1;
                    tmr_val     = PULSE_LOAD;
                    state_next  = PULSE;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
                    retry_next  = '0;
`endif
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LOAD;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (chk_pass) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    ok_next    = 1'b1;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
                end else if (retry_cnt < RETRY_LIMIT) begin
                    retry_next = retry_cnt + 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = PULSE_LOAD;
                    state_next = PULSE;
`endif
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    ok_next    = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // S and R are registered from the next state, so they rise on the
        // accept edge and fall on the edge that leaves PULSE. Both decode
        // from the single target bit, which makes S&&R impossible.
        s_next = (state_next == PULSE) && (target_next == CMD_SET);
        r_next = (state_next == PULSE) && (target_next == CMD_RESET);
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sr_latch_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Directed bench for sr_latch_driver with default parameters
// (PULSE_CYC=2, SETTLE_CYC=2, MAX_RETRY=3). A behavioural NOR latch model
// closes the loop from S/R back to q_fb/qn_fb; an override lets a step
// force the readback. Cycle k in comments is the period after edge k,
// with the command accepted on edge 0.
// ---------------------------------------------------------------------------
module tb_sr_latch_driver;

    import sr_latch_drv_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_set = 1'b0;
    logic       cmd_ready;
    logic       S, R;
    logic       q_fb, qn_fb;
    logic       done, ok, busy;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------ clock
    always #5 clk = ~clk;

    sr_latch_driver dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_set  (cmd_set),
        .cmd_ready(cmd_ready),
        .S        (S),
        .R        (R),
        .q_fb     (q_fb),
        .qn_fb    (qn_fb),
        .done     (done),
        .ok       (ok),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // ----------------------------------------------- NOR latch model
    logic lat_q = 1'b0;
    logic ovr   = 1'b0;
    logic ovr_q = 1'b0;
    logic ovr_qn = 1'b1;

    always @(S, R) begin
        if (S && !R)      lat_q = 1'b1;
        else if (R && !S) lat_q = 1'b0;
    end

    assign q_fb  = ovr ? ovr_q  : lat_q;
    assign qn_fb = ovr ? ovr_qn : ~lat_q;

    // ------------------------------------------------ accept monitor
    int accepts = 0;
    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) accepts++;
    end

    // ------------------------------------------- S/R exclusivity check
    always @(negedge clk) begin
        n_vec++;
        assert ((S && R) === 1'b0)
        else begin
            n_err++;
            $error("FAIL s_and_r_excl observed=%0b expected=0", S && R);
        end
    end

    // ------------------------------------------------------ helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command in the current IDLE cycle; returns in cycle 1.
    task automatic issue(input logic set_val);
        cmd_valid = 1'b1;
        cmd_set   = set_val;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Step until done (bounded); reports the cycle done was seen in and the
    // number of cycles S was high on the way.
    task automatic wait_done(input int start_cyc, output int cyc, output int s_cycles);
        cyc      = start_cyc;
        s_cycles = 0;
        while (!done && cyc < 200) begin
            if (S) s_cycles++;
            tick();
            cyc++;
        end
    endtask

    int cyc, s_cnt, done_cnt, acc0;

    // -------------------------------------------------------- stimulus
    initial begin
        // reset
        repeat (2) @(posedge clk);
        tick();
        rst = 1'b0;
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_state", state_dbg, IDLE);

        // 1) set, cycle by cycle
        issue(CMD_SET);
        chk("set_c1_S", S, 1);
        chk("set_c1_R", R, 0);
        chk("set_c1_busy", busy, 1);
        chk("set_c1_ready", cmd_ready, 0);
        tick();
        chk("set_c2_S", S, 1);
        tick();
        chk("set_c3_S", S, 0);
        chk("set_c3_state", state_dbg, SETTLE);
        tick();
        chk("set_c4_S", S, 0);
        tick();
        chk("set_c5_state", state_dbg, CHECK);
        chk("set_c5_done", done, 0);
        tick();
        chk("set_c6_done", done, 1);
        chk("set_c6_ok", ok, 1);
        chk("set_c6_ready", cmd_ready, 1);
        chk("set_c6_busy", busy, 0);
        chk("set_q", q_fb, 1);
        tick();
        chk("set_c7_done", done, 0);
        chk("set_c7_ok_held", ok, 1);

        // 2) reset command after set
        issue(CMD_RESET);
        chk("rst_cmd_c1_R", R, 1);
        chk("rst_cmd_c1_S", S, 0);
        wait_done(1, cyc, s_cnt);
        chk("rst_cmd_latency", cyc, 6);
        chk("rst_cmd_ok", ok, 1);
        chk("rst_cmd_q", q_fb, 0);
        tick();

        // 3) q_fb stuck at 0 on a set
        ovr = 1'b1; ovr_q = 1'b0; ovr_qn = 1'b1;
        issue(CMD_SET);
        wait_done(1, cyc, s_cnt);
`ifdef SR_LATCH_DRIVER_VERIFY_EN
        chk("stuck_latency", cyc, 21);
        chk("stuck_s_cycles", s_cnt, 8);
        chk("stuck_ok", ok, 0);
`else
        chk("stuck_latency", cyc, 6);
        chk("stuck_s_cycles", s_cnt, 2);
        chk("stuck_ok", ok, 1);
`endif
        ovr = 1'b0;
        tick();

        // 4) invalid readback (Q=Qn=1), released before the retry's CHECK
        ovr = 1'b1; ovr_q = 1'b1; ovr_qn = 1'b1;
        issue(CMD_SET);
        repeat (5) tick();
`ifdef SR_LATCH_DRIVER_VERIFY_EN
        chk("inv_c6_retry_S", S, 1);
        chk("inv_c6_done", done, 0);
        ovr = 1'b0;
        wait_done(6, cyc, s_cnt);
        chk("inv_latency", cyc, 11);
        chk("inv_ok", ok, 1);
`else
        chk("inv_c6_done", done, 1);
        chk("inv_ok", ok, 1);
        ovr = 1'b0;
`endif
        tick();

        // 5) reset asserted during PULSE of a set
        issue(CMD_RESET);
        wait_done(1, cyc, s_cnt);
        chk("pre_rst_latency", cyc, 6);
        issue(CMD_SET);
        chk("mid_c1_S", S, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_S", S, 0);
        chk("mid_rst_R", R, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("mid_rst_no_done", done_cnt, 0);
        issue(CMD_RESET);
        wait_done(1, cyc, s_cnt);
        chk("post_rst_latency", cyc, 6);
        chk("post_rst_ok", ok, 1);
        chk("post_rst_q", q_fb, 0);
        tick();

        // 6) back-to-back with cmd_valid held high
        acc0      = accepts;
        cmd_valid = 1'b1;
        cmd_set   = CMD_RESET;
        tick();
        chk("b2b_c1_R", R, 1);
        for (int c = 1; c < 5; c++) begin
            chk("b2b_busy_ready", cmd_ready, 0);
            tick();
        end
        cmd_set = CMD_SET;
        tick();
        chk("b2b_c6_done", done, 1);
        chk("b2b_c6_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_c7_S", S, 1);
        chk("b2b_c7_done", done, 0);
        wait_done(1, cyc, s_cnt);
        chk("b2b_second_latency", cyc, 6);
        chk("b2b_second_ok", ok, 1);
        chk("b2b_second_q", q_fb, 1);
        chk("b2b_accepts", accepts - acc0, 2);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
